// File: rtl/store_buffer_fwd_pkg.sv
// Shared types for the store buffer: forwarding source tags and the
// hit/conflict decision used by the load forwarding mux.
package store_buffer_fwd_pkg;

   typedef enum logic [1:0] {
      FWD_NONE,
      FWD_COMMIT,
      FWD_SPEC,
      FWD_INCOMING
   } fwd_src_e;

   // Only stores already held in a queue may forward; the in-flight store
   // is always reported as a conflict.
   function automatic logic fwd_is_hit(fwd_src_e src, logic covered);
      return covered && ((src == FWD_SPEC) || (src == FWD_COMMIT));
   endfunction

endpackage

// File: rtl/store_buffer_fwd_sb_queue.sv
// Circular FIFO used for both the speculative and the commit queue. Exposes
// every slot newest-first so the forwarding mux can apply age priority.
module sb_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [W-1:0]           data_i,
   input  logic                   pop_i,
   output logic [$clog2(DEPTH):0] cnt_o,
   output logic [W-1:0]           head_o,
   output logic [DEPTH*W-1:0]     entries_o,
   output logic [DEPTH-1:0]       age_vld_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      vld_d  = vld_q;
      mem_d  = mem_q;
      if (flush_i) begin
         wptr_d = rptr_q;
         cnt_d  = '0;
         vld_d  = '0;
      end else begin
         // Clear before set: when full, push and pop address the same slot.
         if (pop_i) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = rptr_q + PTR_ONE;
         end
         if (push_i) begin
            vld_d[wptr_q] = 1'b1;
            mem_d[wptr_q] = data_i;
            wptr_d        = wptr_q + PTR_ONE;
         end
         if (push_i && !pop_i) begin
            cnt_d = cnt_q + CNT_ONE;
         end else if (pop_i && !push_i) begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         vld_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
         mem_q  <= mem_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign head_o = (cnt_q != '0) ? mem_q[rptr_q] : '0;

   genvar gi;
   generate
      for (gi = 0; gi < int'(DEPTH); gi++) begin : g_age
         logic [PW-1:0] idx;
         assign idx                  = wptr_q - PW'(gi + 1);
         assign entries_o[gi*W +: W] = mem_q[idx];
         assign age_vld_o[gi]        = vld_q[idx];
      end
   endgenerate

   a_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(push_i && !pop_i && !flush_i && (cnt_q == CNT_FULL)));
   a_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(pop_i && !flush_i && (cnt_q == '0)));

endmodule

// File: rtl/store_buffer_fwd.sv
// Store buffer with speculative and commit queues, D$ drain handshake and
// combinational store-to-load forwarding from the youngest matching store.
module store_buffer_fwd
   import store_buffer_fwd_pkg::*;
#(
   parameter int unsigned SPEC_DEPTH   = 4,
   parameter int unsigned COMMIT_DEPTH = 8,
   parameter int unsigned PLEN         = 56,
   parameter int unsigned DATA_W       = 64,
   localparam int unsigned BE_W        = DATA_W / 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic              valid_without_flush_i,
   input  logic [PLEN-1:0]   paddr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [BE_W-1:0]   be_i,
   input  logic [1:0]        data_size_i,
   output logic              ready_o,
   input  logic              commit_i,
   output logic              commit_ready_o,
   output logic              no_st_pending_o,
   output logic              store_buffer_empty_o,
   input  logic              ld_valid_i,
   input  logic [PLEN-1:0]   ld_paddr_i,
   input  logic [BE_W-1:0]   ld_be_i,
   output logic              ld_hit_o,
   output logic [DATA_W-1:0] ld_data_o,
   output logic              ld_conflict_o,
   output logic              st_req_o,
   input  logic              st_gnt_i,
   output logic [PLEN-1:0]   st_addr_o,
   output logic [DATA_W-1:0] st_data_o,
   output logic [BE_W-1:0]   st_be_o,
   output logic [1:0]        st_size_o
);

   localparam int unsigned OFS = $clog2(BE_W);
   localparam int unsigned SPW = $clog2(SPEC_DEPTH);
   localparam int unsigned CPW = $clog2(COMMIT_DEPTH);
   localparam logic [SPW:0] SPEC_RDY_MAX = (SPW+1)'(SPEC_DEPTH - 2);
   localparam logic [CPW:0] COMMIT_FULL  = (CPW+1)'(COMMIT_DEPTH);

   typedef struct packed {
      logic [PLEN-1:0]   paddr;
      logic [DATA_W-1:0] data;
      logic [BE_W-1:0]   be;
      logic [1:0]        size;
   } entry_t;

   localparam int unsigned EW = $bits(entry_t);

   entry_t                       in_entry;
   entry_t                       spec_head;
   entry_t                       commit_head;
   logic [SPW:0]                 spec_cnt;
   logic [CPW:0]                 commit_cnt;
   logic [SPEC_DEPTH*EW-1:0]     spec_flat;
   logic [COMMIT_DEPTH*EW-1:0]   commit_flat;
   logic [SPEC_DEPTH-1:0]        spec_vld;
   logic [COMMIT_DEPTH-1:0]      commit_vld;
   entry_t                       spec_ent   [SPEC_DEPTH];
   entry_t                       commit_ent [COMMIT_DEPTH];
   logic                         st_pop;

   assign in_entry = '{paddr: paddr_i, data: data_i, be: be_i, size: data_size_i};
   assign st_pop   = st_req_o && st_gnt_i;

   sb_queue #(.DEPTH(SPEC_DEPTH), .W(EW)) u_spec_q (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush_i   (flush_i),
      .push_i    (valid_i && !flush_i),
      .data_i    (in_entry),
      .pop_i     (commit_i),
      .cnt_o     (spec_cnt),
      .head_o    (spec_head),
      .entries_o (spec_flat),
      .age_vld_o (spec_vld)
   );

   sb_queue #(.DEPTH(COMMIT_DEPTH), .W(EW)) u_commit_q (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush_i   (1'b0),
      .push_i    (commit_i),
      .data_i    (spec_head),
      .pop_i     (st_pop),
      .cnt_o     (commit_cnt),
      .head_o    (commit_head),
      .entries_o (commit_flat),
      .age_vld_o (commit_vld)
   );

   genvar gi;
   generate
      for (gi = 0; gi < int'(SPEC_DEPTH); gi++) begin : g_spec_unpack
         logic unused_spec_bits;
         assign spec_ent[gi]     = spec_flat[gi*EW +: EW];
         assign unused_spec_bits = ^{spec_ent[gi].paddr[OFS-1:0], spec_ent[gi].size};
      end
      for (gi = 0; gi < int'(COMMIT_DEPTH); gi++) begin : g_commit_unpack
         logic unused_commit_bits;
         assign commit_ent[gi]     = commit_flat[gi*EW +: EW];
         assign unused_commit_bits = ^{commit_ent[gi].paddr[OFS-1:0], commit_ent[gi].size};
      end
   endgenerate

   logic unused_ld_bits;
   assign unused_ld_bits = ^ld_paddr_i[OFS-1:0];

   assign ready_o              = (spec_cnt <= SPEC_RDY_MAX) || commit_i;
   assign commit_ready_o       = commit_cnt < COMMIT_FULL;
   assign no_st_pending_o      = commit_cnt == '0;
   assign store_buffer_empty_o = (spec_cnt == '0) && (commit_cnt == '0);

   assign st_req_o  = commit_cnt != '0;
   assign st_addr_o = commit_head.paddr;
   assign st_data_o = commit_head.data;
   assign st_be_o   = commit_head.be;
   assign st_size_o = commit_head.size;

   fwd_src_e          fwd_src;
   logic [DATA_W-1:0] fwd_data;
   logic [BE_W-1:0]   fwd_be;

   // Scan oldest to youngest so the last match taken is the youngest store.
   always_comb begin
      fwd_src  = FWD_NONE;
      fwd_data = '0;
      fwd_be   = '0;
      for (int i = int'(COMMIT_DEPTH) - 1; i >= 0; i--) begin
         if (commit_vld[i] && (commit_ent[i].paddr[PLEN-1:OFS] == ld_paddr_i[PLEN-1:OFS])) begin
            fwd_src  = FWD_COMMIT;
            fwd_data = commit_ent[i].data;
            fwd_be   = commit_ent[i].be;
         end
      end
      for (int i = int'(SPEC_DEPTH) - 1; i >= 0; i--) begin
         if (spec_vld[i] && (spec_ent[i].paddr[PLEN-1:OFS] == ld_paddr_i[PLEN-1:OFS])) begin
            fwd_src  = FWD_SPEC;
            fwd_data = spec_ent[i].data;
            fwd_be   = spec_ent[i].be;
         end
      end
      if (valid_without_flush_i && (paddr_i[PLEN-1:OFS] == ld_paddr_i[PLEN-1:OFS])) begin
         fwd_src  = FWD_INCOMING;
         fwd_data = data_i;
         fwd_be   = be_i;
      end
      if (!ld_valid_i) begin
         fwd_src = FWD_NONE;
      end
   end

   assign ld_hit_o      = fwd_is_hit(fwd_src, (ld_be_i & ~fwd_be) == '0);
   assign ld_conflict_o = (fwd_src != FWD_NONE) && !ld_hit_o;
   assign ld_data_o     = ld_hit_o ? fwd_data : '0;

   a_flush_commit : assert property (@(posedge clk_i) disable iff (rst_i)
      !(flush_i && commit_i));
   a_hit_conflict : assert property (@(posedge clk_i) disable iff (rst_i)
      !(ld_hit_o && ld_conflict_o));

endmodule

// File: doc/store_buffer_fwd.md
# store_buffer_fwd

Parametrised store buffer with store-to-load forwarding. Holds speculative stores from the LSU, moves them to a non-speculative commit queue on `commit_i`, and drains the commit queue to the D$ via a req/gnt handshake. Unlike the fixed-depth, 64-bit, page-offset-only buffer, it has configurable depths and data width. It also returns forwarded store data to a load when the youngest matching store fully covers the load bytes, and otherwise flags a conflict so the load stalls. Sits between the LSU store unit and the D$ store port.

## Interface
- `SPEC_DEPTH`, 4: speculative entries; power of two, ≥2
- `COMMIT_DEPTH`, 8: commit entries; power of two, ≥2
- `PLEN`, 56: physical address width
- `DATA_W`, 64: store data width; power of two ≥16; `BE_W = DATA_W/8`, `OFS = log2(BE_W)`
- `clk_i` in 1: clock
- `rst_i` in 1: reset, asynchronous, active-high
- `flush_i` in 1: drop all speculative entries
- `valid_i` in 1: push store into speculative queue
- `valid_without_flush_i` in 1: incoming store address is valid (forwarding check only)
- `paddr_i` in PLEN: store physical address
- `data_i` in DATA_W: store data, lane-aligned
- `be_i` in BE_W: store byte enables
- `data_size_i` in 2: log2 of access bytes
- `ready_o` out 1: speculative queue can accept
- `commit_i` in 1: move oldest speculative entry to commit queue
- `commit_ready_o` out 1: commit queue has space
- `no_st_pending_o` out 1: commit queue empty
- `store_buffer_empty_o` out 1: both queues empty
- `ld_valid_i` in 1: load query valid
- `ld_paddr_i` in PLEN: load address
- `ld_be_i` in BE_W: load byte enables
- `ld_hit_o` out 1: forward `ld_data_o`
- `ld_data_o` out DATA_W: forwarded data, 0 when no hit
- `ld_conflict_o` out 1: overlapping store, not forwardable; load must retry
- `st_req_o` out 1: D$ store request
- `st_gnt_i` in 1: D$ grant
- `st_addr_o` out PLEN, `st_data_o` out DATA_W, `st_be_o` out BE_W, `st_size_o` out 2: head of commit queue

## Operation
- Both queues are circular FIFOs with read/write pointers and a count of width log2(depth)+1; pointers wrap naturally.
- `valid_i`: write entry at spec write pointer, count+1. `commit_i`: copy spec head into commit tail, spec count−1, commit count+1. Both in one cycle: net spec count unchanged.
- `ready_o = (spec_cnt ≤ SPEC_DEPTH−2) | commit_i`. `commit_ready_o = commit_cnt < COMMIT_DEPTH`.
- `st_req_o = commit_cnt ≠ 0`. Head pops on `st_req_o & st_gnt_i`. Push and pop in the same cycle leave the count unchanged. `rvalid` is not used; a grant means the store is done.
- `flush_i`: spec count ← 0, write pointer ← read pointer, all spec valids cleared. Commit queue untouched. `flush_i & valid_i`: flush wins, store dropped. `flush_i & commit_i`: illegal (assertion).
- Forwarding (combinational, `ld_valid_i`): entries match on `paddr[PLEN−1:OFS]` equality with a valid bit set. Age order, youngest first:
  - incoming store (`valid_without_flush_i`)
  - speculative entries, newest→oldest
  - commit entries, newest→oldest
- Only the youngest match is considered.
  - Not the incoming store, and `(ld_be_i & ~be) == 0` → `ld_hit_o=1`, `ld_data_o` = entry data.
  - Otherwise (partial coverage, or incoming store matches) → `ld_conflict_o=1`.
  - No match → both 0. `ld_hit_o` and `ld_conflict_o` are never both 1.
- Reset: all counts/pointers 0, all valids 0. Outputs at reset: `ready_o=1`, `commit_ready_o=1`, `no_st_pending_o=1`, `store_buffer_empty_o=1`, `st_req_o=0`, `ld_hit_o=0`, `ld_conflict_o=0`, `ld_data_o=0`, `st_*` data 0. Reset mid-drain drops all entries immediately.

## Timing
- Push-to-visible: an entry is in the queue the cycle after `valid_i`. It is forwardable from that cycle, and flagged as a conflict in the cycle of `valid_without_flush_i`.
- Commit-to-request: `st_req_o` rises the cycle after `commit_i` into an empty commit queue.
- `st_*` are stable while `st_req_o & ~st_gnt_i`. Back-to-back grants drain one entry per cycle.
- The forwarding path is purely combinational, with no registered stage.
- Full spec queue with `commit_i` and `valid_i` in the same cycle is legal.

## Structure
- `ariane_pkg` holds no new types. The entry struct is local, because it is parametrised by `PLEN`/`DATA_W`.
- Sub-module `sb_queue` (params `DEPTH`, entry width) is instantiated twice. It provides push/pop, count, head peek, a flat entry array, and an age-ordered valid vector for the forwarding priority mux.
- Assertions: overflow/underflow on both queues, flush&commit, and hit&conflict exclusivity.

## Test plan
- Push 3 stores (0x1000 / 0x1008 / 0x1010, be=0xFF), commit all, grant each → 3 `st_req_o` beats in order; `no_st_pending_o` returns to 1.
- Store 0x2000 data=0xAABB…, be=0xFF; load 0x2004 be=0xF0 → `ld_hit_o=1`, `ld_data_o=0xAABB…`.
- Store 0x3000 be=0x0F, then load be=0xFF → `ld_conflict_o=1`, `ld_hit_o=0`. Then add a younger store be=0xFF → hit, with the younger data.
- Fill spec queue to SPEC_DEPTH−1, assert `flush_i` → spec count 0, `store_buffer_empty_o` follows the commit queue. Earlier committed entries still drain.
- Fill commit queue with `st_gnt_i=0` → `commit_ready_o=0` at COMMIT_DEPTH. Then one grant plus a simultaneous commit → count stays at COMMIT_DEPTH, pointers wrap correctly.
- Assert `rst_i` with 2 entries pending → next edge all reset values; no `st_req_o`.
